// File: rtl/modexp_stream.sv
// Streaming modular exponentiator: result = m^e mod n. It handles one request at a time
// with a fixed latency and uses bit-serial Blakley modular multipliers.
module modexp_stream #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] n,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, PREP, EXP, HOLD} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  m_q, m_d, e_q, e_d, n_q, n_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  base_q, base_d, res_q, res_d;
    logic [WIDTH-1:0]  acc_sq_q, acc_sq_d, acc_mul_q, acc_mul_d;
    logic [CW-1:0]     bit_q, bit_d, iter_q, iter_d;

    logic [WIDTH-1:0]  prep_step, sq_step, mul_step_v;

    // One Blakley step: P <- 2P + a_bit*b, then at most two subtractions bring it back below modulus.
    // This needs p < modulus and b < modulus. The two spare bits keep 2P + b from overflowing.
    function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] p,
                                                  input logic             a_bit,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] modulus);
        logic [WIDTH+1:0] t;
        t = {1'b0, p, 1'b0} + (a_bit ? {2'b00, b} : {(WIDTH+2){1'b0}});
        if (t >= {2'b00, modulus}) t = t - {2'b00, modulus};
        if (t >= {2'b00, modulus}) t = t - {2'b00, modulus};
        return t[WIDTH-1:0];
    endfunction

    assign prep_step  = mul_step(acc_sq_q, m_q[bit_q], ONE, n_q);
    assign sq_step    = mul_step(acc_sq_q, base_q[bit_q], base_q, n_q);
    assign mul_step_v = mul_step(acc_mul_q, res_q[bit_q], base_q, n_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
            base_q    <= '0;
            res_q     <= '0;
            acc_sq_q  <= '0;
            acc_mul_q <= '0;
            bit_q     <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            e_q       <= e_d;
            n_q       <= n_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
            base_q    <= base_d;
            res_q     <= res_d;
            acc_sq_q  <= acc_sq_d;
            acc_mul_q <= acc_mul_d;
            bit_q     <= bit_d;
            iter_q    <= iter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        e_d       = e_q;
        n_d       = n_q;
        tag_d     = tag_q;
        err_d     = err_q;
        base_d    = base_q;
        res_d     = res_q;
        acc_sq_d  = acc_sq_q;
        acc_mul_d = acc_mul_q;
        bit_d     = bit_q;
        iter_d    = iter_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d       = m;
                    e_d       = e;
                    n_d       = n;
                    tag_d     = in_tag;
                    base_d    = '0;
                    acc_sq_d  = '0;
                    acc_mul_d = '0;
                    bit_d     = LAST;
                    iter_d    = '0;
                    res_d     = '0;
                    err_d     = 1'b0;
                    // A modulus of 0 or 1 has a trivial answer, so the multiply pipeline is skipped.
                    if (n == '0) begin
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end else if (n == ONE) begin
                        state_d = HOLD;
                    end else begin
                        res_d   = ONE;
                        state_d = PREP;
                    end
                end
            end
            PREP: begin
                acc_sq_d = prep_step;
                if (bit_q == '0) begin
                    base_d   = prep_step;
                    acc_sq_d = '0;
                    bit_d    = LAST;
                    state_d  = EXP;
                end else begin
                    bit_d = bit_q - CW'(1);
                end
            end
            EXP: begin
                acc_sq_d  = sq_step;
                acc_mul_d = mul_step_v;
                if (bit_q == '0) begin
                    // The result multiply always runs so that every exponent bit takes the same time.
                    base_d    = sq_step;
                    if (e_q[iter_q]) res_d = mul_step_v;
                    acc_sq_d  = '0;
                    acc_mul_d = '0;
                    bit_d     = LAST;
                    if (iter_q == LAST) state_d = HOLD;
                    else                iter_d  = iter_q + CW'(1);
                end else begin
                    bit_d = bit_q - CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign result    = res_q;
    assign out_tag   = tag_q;
    assign err       = err_q;

endmodule

// File: tb/tb_modexp_stream.sv
// Testbench for modexp_stream at WIDTH=16.
// Directed vectors and corner sequences are checked, then random requests are compared against a plain-arithmetic model.
module tb_modexp_stream;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] m, e, n;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  out_tag;
   logic        err;

   modexp_stream #(.WIDTH(16), .TAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .m(m), .e(e), .n(n), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_tag(out_tag), .err(err)
   );

   typedef struct {
      logic [15:0] m;
      logic [15:0] e;
      logic [15:0] n;
      logic [3:0]  tag;
      logic [15:0] res;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  tag;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   seen = 0;
   bit   ready_mode = 0;
   logic ready_force = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
   end

   // Square-and-multiply reference, written directly from the definition of m^e mod n
   function automatic logic [15:0] ref_modexp(input logic [15:0] mm, input logic [15:0] ee,
                                              input logic [15:0] nn);
      longint unsigned r, b;
      if (nn <= 16'd1) return 16'd0;
      r = 1;
      b = longint'(mm) % longint'(nn);
      for (int i = 0; i < 16; i++) begin
         if (ee[i]) r = (r * b) % longint'(nn);
         b = (b * b) % longint'(nn);
      end
      return r[15:0];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bounded wait expired (t=%0t)", name, $time);
   endtask

   // Offer a request and wait for it to be accepted. The expected response is queued for the monitor.
   task automatic applyStimulus(input logic [15:0] mm, input logic [15:0] ee, input logic [15:0] nn,
                                input logic [3:0] tg, input logic [15:0] res, input logic er,
                                input int lat);
      exp_t x;
      int   t;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      m = mm;
      e = ee;
      n = nn;
      in_tag = tg;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 3000);
      if (!in_ready) begin
         failNow("accept_timeout");
         in_valid = 1'b0;
         return;
      end
      x.res = res;
      x.tag = tg;
      x.err = er;
      x.lat = lat;
      x.acc = cyc + 1;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      m = 16'($urandom);
      e = 16'($urandom);
      n = 16'($urandom);
      in_tag = 4'($urandom);
   endtask

   task automatic waitDrain();
      int t = 0;
      while ((exp_q.size() != 0 || !in_ready) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0 || !in_ready) failNow("drain_timeout");
   endtask

   // Response monitor: checks latency on the first cycle out_valid is seen, and checks values at the handshake
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (out_valid && !seen) begin
            seen = 1;
            if (exp_q.size() == 0) failNow("spurious_response");
            else checkOutput("latency", 64'(cyc + 1 - exp_q[0].acc), 64'(exp_q[0].lat));
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checkOutput("result", 64'(result), 64'(x.res));
            checkOutput("out_tag", 64'(out_tag), 64'(x.tag));
            checkOutput("err", 64'(err), 64'(x.err));
            seen = 0;
         end
      end
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, "_result"}, 64'(result), 64'd0);
      checkOutput({tag, "_out_tag"}, 64'(out_tag), 64'd0);
      checkOutput({tag, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      vec_t        vecs[8];
      logic [15:0] hold_res;
      logic [3:0]  hold_tag;
      logic        hold_err;
      int          t;

      vecs[0] = '{m:16'd21,    e:16'd4,     n:16'd133,   tag:4'd3,  res:16'd35,  err:1'b0, lat:273};
      vecs[1] = '{m:16'd4,     e:16'd13,    n:16'd497,   tag:4'd5,  res:16'd445, err:1'b0, lat:273};
      vecs[2] = '{m:16'd200,   e:16'd3,     n:16'd13,    tag:4'd6,  res:16'd8,   err:1'b0, lat:273};
      vecs[3] = '{m:16'd5,     e:16'd0,     n:16'd7,     tag:4'd7,  res:16'd1,   err:1'b0, lat:273};
      vecs[4] = '{m:16'd1234,  e:16'd77,    n:16'd0,     tag:4'd8,  res:16'd0,   err:1'b1, lat:1};
      vecs[5] = '{m:16'd999,   e:16'd5,     n:16'd1,     tag:4'd9,  res:16'd0,   err:1'b0, lat:1};
      vecs[6] = '{m:16'd65535, e:16'd65535, n:16'd65535, tag:4'd15, res:16'd0,   err:1'b0, lat:273};
      vecs[7] = '{m:16'd0,     e:16'd0,     n:16'd2,     tag:4'd1,  res:16'd1,   err:1'b0, lat:273};

      rst = 1'b0;
      in_valid = 1'b0;
      m = '0;
      e = '0;
      n = '0;
      in_tag = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].tag, vecs[i].res, vecs[i].err, vecs[i].lat);
         waitDrain();
      end

      // Backpressure: the response must stay put and new requests must be ignored while out_ready is low
      ready_force = 1'b0;
      applyStimulus(16'd21, 16'd4, 16'd133, 4'd11, 16'd35, 1'b0, 273);
      t = 0;
      while (!out_valid && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) failNow("bp_valid_timeout");
      hold_res = result;
      hold_tag = out_tag;
      hold_err = err;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         in_valid = k[0];
         m = 16'($urandom);
         n = 16'd0;
         in_tag = 4'($urandom);
         @(negedge clk);
         checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
         checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
         checkOutput("bp_result", 64'(result), 64'(hold_res));
         checkOutput("bp_out_tag", 64'(out_tag), 64'(hold_tag));
         checkOutput("bp_err", 64'(err), 64'(hold_err));
      end
      in_valid = 1'b0;
      ready_force = 1'b1;
      t = 0;
      while (!(out_valid && out_ready) && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!(out_valid && out_ready)) failNow("bp_handshake_timeout");
      @(negedge clk);
      checkOutput("bp_retire_in_ready", 64'(in_ready), 64'd1);
      checkOutput("bp_retire_out_valid", 64'(out_valid), 64'd0);
      waitDrain();

      // Reset in the middle of EXP: the in-flight request is discarded and no response may appear for it
      applyStimulus(16'd77, 16'd9, 16'd1001, 4'd12, ref_modexp(16'd77, 16'd9, 16'd1001), 1'b0, 273);
      repeat (99) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkResetOutputs("midexp_reset");
      exp_q.delete();
      seen = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(16'd21, 16'd4, 16'd133, 4'd3, 16'd35, 1'b0, 273);
      waitDrain();

      // Random regression with random request gaps and random out_ready
      ready_mode = 1;
      for (int i = 0; i < 150; i++) begin
         logic [15:0] rm, re, rn;
         rm = 16'($urandom);
         re = 16'($urandom);
         rn = 16'($urandom_range(2, 65535));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         applyStimulus(rm, re, rn, 4'(i), ref_modexp(rm, re, rn), 1'b0, 273);
      end
      waitDrain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
